// File: rtl/max_reduce_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// max_reduce_ctrl_pkg
//  Shared definitions for the argmax reduction controller:
//   - state_t : controller FSM encoding (IDLE / RUN / DONE)
//   - int_min : builds the most negative two's-complement value for a width
// -----------------------------------------------------------------------------
package max_reduce_ctrl_pkg;

   // Widest element the int_min helper can describe; callers slice the result.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Most negative signed value of width w, right-aligned in a MAX_W vector.
   // Used as the result of an empty job.
   function automatic logic [MAX_W-1:0] int_min(input int w);
      logic [MAX_W-1:0] r;
      r        = '0;
      r[w-1]   = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/max_reduce_ctrl_gt.sv
// -----------------------------------------------------------------------------
// gt_int_nbit
//  Strict signed greater-than comparator: gt = (a > b), two's complement.
//  IMPL_TYPE picks the structure; every variant computes the same function.
//   0     : native signed compare
//   1     : sign-bit flip then unsigned compare
//   other : (WIDTH+1)-bit subtract, positive non-zero difference
// Ports
//   a, b  in  WIDTH  signed operands
//   gt    out 1      a > b
// -----------------------------------------------------------------------------
module gt_int_nbit #(
   parameter int WIDTH     = 32,
   parameter int IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt
);

   generate
      if (IMPL_TYPE == 0) begin : g_native
         assign gt = $signed(a) > $signed(b);
      end else if (IMPL_TYPE == 1) begin : g_flip
         // Flipping the sign bit maps signed order onto unsigned order.
         logic [WIDTH-1:0] a_f, b_f;
         assign a_f = {~a[WIDTH-1], a[WIDTH-2:0]};
         assign b_f = {~b[WIDTH-1], b[WIDTH-2:0]};
         assign gt  = a_f > b_f;
      end else begin : g_sub
         // One extra bit of sign extension makes the difference exact, so
         // its sign bit never overflows.
         logic [WIDTH:0] diff;
         assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
         assign gt   = ~diff[WIDTH] & (|diff);
      end
   endgenerate

endmodule

// File: rtl/max_reduce_ctrl.sv
// -----------------------------------------------------------------------------
// max_reduce_ctrl
//  Sequential argmax over a signed element stream. A job (start + len) is
//  captured in IDLE, len elements are consumed over valid/ready, and one
//  shared comparator checks each element against the running maximum. The
//  result (max value, index of first occurrence) is held until out_ready.
// Ports
//   clk, rst_n        clock, async active-low reset
//   start, len        job request and element count (sampled in IDLE only)
//   in_valid/in_data  element stream, in_ready = controller is in RUN
//   busy              RUN or DONE
//   out_valid         result valid (DONE), held until out_ready
//   out_max, out_idx  maximum element and its 0-based first index
//   out_ready         result consumer ready
// -----------------------------------------------------------------------------
module max_reduce_ctrl
   import max_reduce_ctrl_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int IMPL_TYPE = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_max,
   output logic [CNT_W-1:0] out_idx,
   input  logic             out_ready
);

   localparam logic [MAX_W-1:0] INT_MIN_FULL = int_min(WIDTH);
   localparam logic [WIDTH-1:0] INT_MIN      = INT_MIN_FULL[WIDTH-1:0];
   localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

   state_t           state_r, state_nx;
   logic [CNT_W-1:0] len_r, cnt_r, idx_r;
   logic [WIDTH-1:0] max_r;
   logic             xfer, last, gt;

   // Single comparator, time-shared across all elements of the job.
   gt_int_nbit #(
      .WIDTH     (WIDTH),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_gt (
      .a  (in_data),
      .b  (max_r),
      .gt (gt)
   );

   assign in_ready  = (state_r == RUN);
   assign xfer      = in_valid && in_ready;
   assign last      = (cnt_r == len_r - ONE);
   assign busy      = (state_r != IDLE);
   assign out_valid = (state_r == DONE);
   // max_r/idx_r freeze outside RUN, so they double as the result registers.
   assign out_max   = max_r;
   assign out_idx   = idx_r;

   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: if (start)         state_nx = (len == '0) ? DONE : RUN;
         RUN:  if (xfer && last)  state_nx = DONE;
         DONE: if (out_ready)     state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         len_r   <= '0;
         cnt_r   <= '0;
         idx_r   <= '0;
         max_r   <= '0;
      end else begin
         state_r <= state_nx;
         if (state_r == IDLE && start) begin
            len_r <= len;
            cnt_r <= '0;
            idx_r <= '0;
            // An empty job reports INT_MIN; otherwise element 0 overwrites it.
            max_r <= INT_MIN;
         end
         if (xfer) begin
            cnt_r <= cnt_r + ONE;
            // Element 0 loads unconditionally; later ones only on strict >,
            // so ties keep the earlier index.
            if (cnt_r == '0 || gt) begin
               max_r <= in_data;
               idx_r <= cnt_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_max_reduce_ctrl.sv
module tb_max_reduce_ctrl;
   localparam int WIDTH = 32;
   localparam int CNT_W = 16;
   localparam int EW    = WIDTH + CNT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_ready = 1'b1;
   logic             in_ready, busy, out_valid;
   logic [WIDTH-1:0] out_max;
   logic [CNT_W-1:0] out_idx;

   always #5 clk = ~clk;

   max_reduce_ctrl #(.WIDTH(WIDTH), .IMPL_TYPE(0), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .out_valid(out_valid), .out_max(out_max),
      .out_idx(out_idx), .out_ready(out_ready)
   );

   int n_chk = 0, n_fail = 0;
   int hs_cnt = 0, hs_base = 0;
   int gap_pct = 0;
   bit rand_rdy = 1'b0;
   logic [WIDTH-1:0] job_q[$];
   logic [EW-1:0]    exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: first index holding the largest signed value; empty -> INT_MIN/0.
   function automatic logic [EW-1:0] ref_model();
      int best, bi;
      logic [WIDTH-1:0] bv;
      logic [CNT_W-1:0] bidx;
      if (job_q.size() == 0) return {1'b1, {(WIDTH-1){1'b0}}, {CNT_W{1'b0}}};
      best = int'(job_q[0]);
      bi   = 0;
      foreach (job_q[i]) if (int'(job_q[i]) > best) begin best = int'(job_q[i]); bi = i; end
      bv   = best;
      bidx = bi[CNT_W-1:0];
      return {bv, bidx};
   endfunction

   // Monitor: compares each presented result with the scoreboard head and
   // checks it stays stable until the handshake.
   bit               in_res = 1'b0;
   logic [WIDTH-1:0] h_max;
   logic [CNT_W-1:0] h_idx;
   logic [EW-1:0]    e;
   always @(negedge clk) begin
      if (!rst_n) in_res = 1'b0;
      else if (out_valid) begin
         if (!in_res) begin
            in_res = 1'b1;
            h_max  = out_max;
            h_idx  = out_idx;
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_result: got %0h/%0d expected none", out_max, out_idx);
            end else begin
               e = exp_q[0];
               check("result_max", out_max, e[EW-1:CNT_W]);
               check("result_idx", out_idx, e[CNT_W-1:0]);
            end
         end else begin
            check("hold_max", out_max, h_max);
            check("hold_idx", out_idx, h_idx);
         end
         if (out_ready) begin
            in_res = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            hs_cnt++;
         end
      end
   end

   task automatic drive_elem(input logic [WIDTH-1:0] d);
      int t = 0, g = 0;
      bit ok = 1'b0;
      while (gap_pct > 0 && g < 8 && $urandom_range(99) < gap_pct) begin
         in_valid = 1'b0; g++;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      while (!ok) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1;
         t++;
         if (!ok && t > 50) begin
            n_chk++; n_fail++;
            $display("FAIL elem_timeout: got in_ready=0 for %0d cycles expected 1", t);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Issues job_q as one job; called at #1 after a rising edge with DUT idle.
   task automatic run_job(input bit inj);
      int L = job_q.size();
      exp_q.push_back(ref_model());
      hs_base = hs_cnt;
      start = 1'b1; len = CNT_W'(L);
      @(posedge clk); #1;
      start = 1'b0;
      foreach (job_q[k]) begin
         if (inj && k == 1) begin start = 1'b1; len = CNT_W'(1); end
         drive_elem(job_q[k]);
         start = 1'b0;
      end
      @(negedge clk);
      check("lat_out_valid", out_valid, 1);
      check("lat_in_ready", in_ready, 0);
   endtask

   task automatic wait_hs();
      int t = 0;
      do begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         t++;
      end while (hs_cnt == hs_base && t < 300);
      if (hs_cnt == hs_base) begin
         n_chk++; n_fail++;
         $display("FAIL hs_timeout: got no handshake in %0d cycles expected one", t);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] v;
      int n;
      // Reset state
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_max", out_max, 0);
      check("rst_out_idx", out_idx, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: ties keep first index
      job_q = '{32'd3, -32'sd7, 32'd9, 32'd9};
      run_job(0); wait_hs();

      // 2: full signed range
      job_q = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      run_job(0); wait_hs();

      // 3: empty job; then start held through the handshake cycle is ignored
      job_q = {};
      out_ready = 1'b0;
      run_job(0);
      @(posedge clk); #1;
      start = 1'b1; len = CNT_W'(5); out_ready = 1'b1;
      wait_hs();
      start = 1'b0;
      @(negedge clk);
      check("hs_start_ignored_busy", busy, 0);
      @(posedge clk); #1;

      // 4: all -1, input gaps, result held with out_ready low
      gap_pct = 40;
      out_ready = 1'b0;
      job_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      run_job(0);
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      check("held_out_valid", out_valid, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_hs();
      gap_pct = 0;

      // 5: reset mid-job, then a fresh job
      start = 1'b1; len = CNT_W'(6);
      @(posedge clk); #1; start = 1'b0;
      drive_elem(32'd100);
      drive_elem(32'd200);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 0);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_out_max", out_max, 0);
      check("abort_out_idx", out_idx, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      job_q = '{32'd42};
      run_job(0); wait_hs();

      // 6: start during RUN ignored
      job_q = '{32'd5, -32'sd2, 32'd17};
      run_job(1); wait_hs();

      // Random jobs with gaps, random out_ready, frequent ties and extremes
      rand_rdy = 1'b1;
      gap_pct  = 30;
      for (int j = 0; j < 25; j++) begin
         job_q = {};
         n = (j % 9 == 8) ? 0 : int'($urandom_range(1, 24));
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
               0: v = 32'h8000_0000;
               1: v = 32'h7FFF_FFFF;
               2: begin v = $urandom_range(0, 6); v = v - 32'd3; end
               default: v = $urandom;
            endcase
            job_q.push_back(v);
         end
         run_job(0); wait_hs();
      end

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
